// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority-encoder family: mode encodings and
// a width helper that never returns zero.
package prio_enc_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n lines; at least 1 bit so a 2-line (or degenerate) encoder
   // still has a legal index port.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection. Fixed mode picks the highest set index.
// Round-robin rotates the request vector so that line ptr lands at bit 0,
// picks the lowest set bit of the rotated vector and maps it back.
module rr_pick
   import prio_enc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = clog2_safe(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         multi
);

   logic [N-1:0] rot;
   logic [W-1:0] fix_idx;
   logic [W-1:0] rot_off;
   logic [W-1:0] rr_idx;
   logic [W:0]   unrot_sum;

   // Rotation with an explicit modulo-N wrap so non-power-of-2 N works;
   // ptr <= N-1 keeps the sum below 2N, so one subtraction suffices.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         logic [W:0]   src_sum;
         logic [W-1:0] src;
         assign src_sum = {1'b0, ptr} + (W+1)'(gi);
         assign src     = (src_sum >= (W+1)'(N)) ? W'(src_sum - (W+1)'(N)) : W'(src_sum);
         assign rot[gi] = req[src];
      end
   endgenerate

   // Fixed priority: the last assignment in an ascending scan is the highest set bit.
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) fix_idx = W'(i);
      end
   end

   // Round-robin offset: the last assignment in a descending scan is the lowest set bit.
   always_comb begin
      rot_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) rot_off = W'(i);
      end
   end

   assign unrot_sum = {1'b0, rot_off} + {1'b0, ptr};

   // Map the rotated offset back to an absolute line number, wrapping at N.
   always_comb begin
      if (unrot_sum >= (W+1)'(N)) rr_idx = W'(unrot_sum - (W+1)'(N));
      else                        rr_idx = W'(unrot_sum);
   end

   assign any   = |req;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = |(req & (req - N'(1)));
   assign idx   = !any ? '0 : ((mode == MODE_RR) ? rr_idx : fix_idx);

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with valid/ready on both sides. Holds the
// one-deep output register, the handshake and the round-robin pointer.
module prio_encoder_rr
   import prio_enc_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = clog2_safe(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_any,
   output logic         out_multi
);

   logic [W-1:0] ptr_reg;
   logic [W-1:0] pick_idx;
   logic         pick_any;
   logic         pick_multi;
   logic         accept;

   rr_pick #(.N(N)) u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .mode  (mode),
      .idx   (pick_idx),
      .any   (pick_any),
      .multi (pick_multi)
   );

   // Accept whenever the slot is empty or being drained this cycle.
   assign in_ready = !out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Output register and pointer; the pointer only moves on a round-robin win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_any   <= 1'b0;
         out_multi <= 1'b0;
         ptr_reg   <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= pick_idx;
            out_any   <= pick_any;
            out_multi <= pick_multi;
            if ((mode == MODE_RR) && pick_any) begin
               ptr_reg <= (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: an 8-line and a 5-line instance driven
// from one initial block, with a behavioural model feeding a scoreboard.
module tb_prio_encoder_rr;

   localparam int NA = 8;
   localparam int NB = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NA-1:0] a_req;
   logic          a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_any, a_multi;
   logic [2:0]    a_idx;

   logic [NB-1:0] b_req;
   logic          b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_any, b_multi;
   logic [2:0]    b_idx;

   prio_encoder_rr #(.N(NA)) u_dut_a (
      .clk(clk), .rst(rst), .req(a_req), .mode(a_mode), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_idx(a_idx), .out_any(a_any), .out_multi(a_multi)
   );

   prio_encoder_rr #(.N(NB)) u_dut_b (
      .clk(clk), .rst(rst), .req(b_req), .mode(b_mode), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_idx(b_idx), .out_any(b_any), .out_multi(b_multi)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic       any;
      logic       multi;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   logic m_valid[2];
   int   m_ptr[2];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference encoder: plain scans, no rotation.
   function automatic exp_t model(input logic [7:0] r, input int n, input logic md, input int p);
      exp_t e;
      int   cnt;
      logic found;
      e     = '0;
      cnt   = 0;
      found = 1'b0;
      for (int k = 0; k < n; k++) if (r[k]) cnt++;
      e.any   = (cnt >= 1);
      e.multi = (cnt >= 2);
      if (!md) begin
         for (int k = 0; k < n; k++) if (r[k]) e.idx = 3'(k);
      end else begin
         for (int k = 0; k < n; k++) begin
            int j;
            j = (p + k) % n;
            if (r[j] && !found) begin
               e.idx = 3'(j);
               found = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic check(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Checks one instance for the current cycle and updates its model.
   task automatic side(input int d, input int n, input logic [7:0] r, input logic md,
                       input logic iv, input logic ordy, input logic ir, input logic ov,
                       input logic [2:0] idx, input logic any, input logic multi);
      exp_t e;
      logic rdy;
      string pfx;
      pfx = (d == 0) ? "a_" : "b_";
      rdy = !m_valid[d] || ordy;
      check({pfx, "in_ready"}, int'(ir), int'(rdy));
      check({pfx, "out_valid"}, int'(ov), int'(m_valid[d]));
      if (m_valid[d]) begin
         e = (d == 0) ? q_a[0] : q_b[0];
         check({pfx, "out_idx"}, int'(idx), int'(e.idx));
         check({pfx, "out_any"}, int'(any), int'(e.any));
         check({pfx, "out_multi"}, int'(multi), int'(e.multi));
         if (ordy) begin
            if (d == 0) void'(q_a.pop_front());
            else        void'(q_b.pop_front());
            m_valid[d] = 1'b0;
         end
      end
      if (iv && rdy) begin
         e = model(r, n, md, m_ptr[d]);
         if (d == 0) q_a.push_back(e);
         else        q_b.push_back(e);
         m_valid[d] = 1'b1;
         if (md && e.any) m_ptr[d] = (int'(e.idx) == n - 1) ? 0 : int'(e.idx) + 1;
      end
   endtask

   task automatic cycle();
      #1;
      side(0, NA, a_req, a_mode, a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_idx, a_any, a_multi);
      side(1, NB, {3'b000, b_req}, b_mode, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_idx, b_any, b_multi);
      $display("t=%0t a: req=%h mode=%0d iv=%0d ordy=%0d -> ov=%0d idx=%0d any=%0d multi=%0d | b: req=%h iv=%0d -> ov=%0d idx=%0d",
               $time, a_req, a_mode, a_in_valid, a_out_ready, a_out_valid, a_idx, a_any, a_multi,
               b_req, b_in_valid, b_out_valid, b_idx);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      m_ptr[0]   = 0;
      m_ptr[1]   = 0;
      q_a.delete();
      q_b.delete();
   endtask

   initial begin
      rst = 1'b1;
      a_req = '0; a_mode = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_req = '0; b_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_out_valid", int'(a_out_valid), 0);
      check("rst_out_idx", int'(a_idx), 0);
      check("rst_out_any", int'(a_any), 0);
      check("rst_out_multi", int'(a_multi), 0);
      check("rst_b_out_valid", int'(b_out_valid), 0);

      // 1. One-hot sweep, fixed mode
      a_in_valid = 1'b1;
      for (int i = 0; i < NA; i++) begin
         a_req = 8'(1 << i);
         cycle();
      end

      // 2. Fixed priority with several bits set, then all-zero
      a_req = 8'b0010_0110; cycle();
      a_req = 8'h00;        cycle();
      a_in_valid = 1'b0;    cycle();

      // 3. Round-robin over a full request vector, wrapping 7 -> 0
      a_mode = 1'b1; a_in_valid = 1'b1; a_req = 8'hFF;
      repeat (9) cycle();

      // 4. Two lines alternating, with an all-zero accept in between
      a_req = 8'b1000_0010; cycle();
      a_req = 8'h00;        cycle();
      a_req = 8'b1000_0010; repeat (3) cycle();

      // 5. Backpressure then release with drain and accept in the same cycle
      a_req = 8'hFF; a_out_ready = 1'b0;
      repeat (3) cycle();
      a_out_ready = 1'b1;
      repeat (2) cycle();

      // Mode switch: fixed pick, then round-robin resumes from retained pointer
      a_mode = 1'b0; cycle();
      a_mode = 1'b1; repeat (2) cycle();

      // 6. Five-line instance in round-robin while the 8-line one keeps streaming
      b_mode = 1'b1; b_in_valid = 1'b1; b_req = 5'b11111;
      repeat (7) cycle();

      // Asynchronous reset in the middle of a cycle
      #2 rst = 1'b1;
      #1;
      check("async_rst_a_out_valid", int'(a_out_valid), 0);
      check("async_rst_b_out_valid", int'(b_out_valid), 0);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      cycle();
      a_in_valid = 1'b1; b_in_valid = 1'b1;
      repeat (3) cycle();
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
